// File: rtl/dmem_bus_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the data-memory bus controller.
//   state_t     : controller FSM state encoding (2 bits)
//   acc_kind_t  : access kind, ACC_LOAD / ACC_STORE
//   acc_kind()  : classifies an access from its byte write enables
//   DEF_TIMEOUT_CYCLES : default watchdog limit in REQ+WAIT_R cycles
// -----------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef enum logic {
        ACC_LOAD  = 1'b0,
        ACC_STORE = 1'b1
    } acc_kind_t;

    localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

    // Any nonzero byte enable makes the access a store, whatever re says.
    function automatic acc_kind_t acc_kind(input logic [3:0] we);
        return (|we) ? ACC_STORE : ACC_LOAD;
    endfunction

endpackage

// File: rtl/dmem_bus_ctrl_if.sv
// -----------------------------------------------------------------------------
// dmem_bus_ctrl_if
// Request/grant/rvalid bus between the data-memory controller and the slave.
//   req    : master -> slave, request valid; addr/we/wdata stable while high
//   addr   : master -> slave, word address
//   we     : master -> slave, byte write enables, 0 = read
//   wdata  : master -> slave, write data
//   gnt    : slave -> master, request accepted this cycle
//   rvalid : slave -> master, read data valid
//   rdata  : slave -> master, read data
//
// Handshake: a request transfers on a cycle where req && gnt. The master keeps
// req, addr, we and wdata unchanged until that cycle. For reads the slave
// returns exactly one rvalid pulse, no earlier than the cycle after the grant;
// rvalid has no ready and must be taken when offered.
// -----------------------------------------------------------------------------
interface dmem_bus_ctrl_if;

    logic        req;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, addr, we, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr, we, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/dmem_bus_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_bus_ctrl
// Turns the core's single-cycle data-memory access into a req/gnt/rvalid bus
// transaction, stalling the core until it completes or the watchdog expires.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   cpu_re_i      : load request
//   cpu_we_i      : byte write enables, nonzero = store
//   cpu_addr_i    : byte address
//   cpu_wdata_i   : store data
//   cpu_rdata_o   : load data, valid in DONE, held until the next DONE
//   cpu_stall_o   : core holds while high
//   cpu_err_o     : one-cycle pulse in DONE after a timeout
//   bus           : master side of dmem_bus_ctrl_if
//   dbg_state_o   : current FSM state
// -----------------------------------------------------------------------------
module dmem_bus_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_re_i,
    input  logic [3:0]             cpu_we_i,
    input  logic [31:0]            cpu_addr_i,
    input  logic [31:0]            cpu_wdata_i,
    output logic [31:0]            cpu_rdata_o,
    output logic                   cpu_stall_o,
    output logic                   cpu_err_o,
    dmem_bus_ctrl_if.master        bus,
    output state_t                 dbg_state_o
);

    // The counter holds the number of REQ+WAIT_R cycles already completed, so
    // a value of TIMEOUT_CYCLES-1 marks the last cycle the slave is allowed.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [3:0]        we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              acc;
    logic              is_store;
    logic              last_cycle;
    logic [CNT_W-1:0]  cnt_inc;

    // Byte lanes below the word boundary are dropped on the bus.
    logic              unused_addr_lsbs;
    assign unused_addr_lsbs = ^cpu_addr_i[1:0];

    assign acc        = cpu_re_i | (|cpu_we_i);
    assign is_store   = (acc_kind(we_q) == ACC_STORE);
    assign last_cycle = (cnt_q == CNT_LAST);
    assign cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (acc) begin
                    state_d = REQ;
                    cnt_d   = '0;
                    addr_d  = {cpu_addr_i[31:2], 2'b00};
                    we_d    = cpu_we_i;
                    wdata_d = cpu_wdata_i;
                end
            end

            REQ: begin
                cnt_d = cnt_inc;
                // A store granted on its last allowed cycle has completed on
                // the bus, so it finishes cleanly. A load granted on its last
                // cycle has no time left for data and is aborted.
                if (bus.gnt && is_store) begin
                    state_d = DONE;
                end else if (last_cycle) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    if (!is_store) begin
                        rdata_d = '0;
                    end
                end else if (bus.gnt) begin
                    // rvalid in this same cycle is a protocol violation and
                    // is not looked at.
                    state_d = WAIT_R;
                end
            end

            WAIT_R: begin
                cnt_d = cnt_inc;
                if (bus.rvalid) begin
                    state_d = DONE;
                    rdata_d = bus.rdata;
                end else if (last_cycle) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end

            DONE: begin
                // The core advances in DONE, so a still-high acc is a new
                // access and is picked up in the following IDLE cycle.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.req     = (state_q == REQ);
    assign bus.addr    = addr_q;
    assign bus.we      = we_q;
    assign bus.wdata   = wdata_q;

    assign cpu_rdata_o = rdata_q;
    assign cpu_err_o   = err_q;
    assign cpu_stall_o = ((state_q == IDLE) && acc) ||
                         (state_q == REQ) || (state_q == WAIT_R);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_bus_ctrl
// Directed bench for dmem_bus_ctrl. u_dut uses the default watchdog, u_to uses
// a 4-cycle watchdog; both share the core-side stimulus and the slave drive.
// -----------------------------------------------------------------------------
module tb_dmem_bus_ctrl;
    import dmem_pkg::*;

    logic        clk;
    logic        rst;
    logic        cpu_re;
    logic [3:0]  cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        s_gnt;
    logic        s_rvalid;
    logic [31:0] s_rdata;

    logic [31:0] a_rdata, b_rdata;
    logic        a_stall, b_stall;
    logic        a_err, b_err;
    state_t      a_state, b_state;

    int checks;
    int failures;

    dmem_bus_ctrl_if bus_a ();
    dmem_bus_ctrl_if bus_b ();

    assign bus_a.gnt    = s_gnt;
    assign bus_a.rvalid = s_rvalid;
    assign bus_a.rdata  = s_rdata;
    assign bus_b.gnt    = s_gnt;
    assign bus_b.rvalid = s_rvalid;
    assign bus_b.rdata  = s_rdata;

    dmem_bus_ctrl u_dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_re_i    (cpu_re),
        .cpu_we_i    (cpu_we),
        .cpu_addr_i  (cpu_addr),
        .cpu_wdata_i (cpu_wdata),
        .cpu_rdata_o (a_rdata),
        .cpu_stall_o (a_stall),
        .cpu_err_o   (a_err),
        .bus         (bus_a),
        .dbg_state_o (a_state)
    );

    dmem_bus_ctrl #(.TIMEOUT_CYCLES(4)) u_to (
        .clk         (clk),
        .rst         (rst),
        .cpu_re_i    (cpu_re),
        .cpu_we_i    (cpu_we),
        .cpu_addr_i  (cpu_addr),
        .cpu_wdata_i (cpu_wdata),
        .cpu_rdata_o (b_rdata),
        .cpu_stall_o (b_stall),
        .cpu_err_o   (b_err),
        .bus         (bus_b),
        .dbg_state_o (b_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        cpu_re    = 1'b0;
        cpu_we    = 4'h0;
        cpu_addr  = 32'h0;
        cpu_wdata = 32'h0;
        s_gnt     = 1'b0;
        s_rvalid  = 1'b0;
        s_rdata   = 32'h0;

        // Reset state
        tick();
        tick();
        chk("rst_state", 32'(a_state), 32'(IDLE));
        chk("rst_req",   32'(bus_a.req), 32'h0);
        chk("rst_addr",  bus_a.addr, 32'h0);
        chk("rst_we",    32'(bus_a.we), 32'h0);
        chk("rst_wdata", bus_a.wdata, 32'h0);
        chk("rst_rdata", a_rdata, 32'h0);
        chk("rst_err",   32'(a_err), 32'h0);
        chk("rst_stall", 32'(a_stall), 32'h0);
        rst = 1'b0;
        tick();

        // Full-word store, granted on the first REQ cycle
        cpu_we = 4'hF; cpu_addr = 32'h100; cpu_wdata = 32'hCAFEBABE; s_gnt = 1'b1;
        #1;
        chk("st_idle_stall", 32'(a_stall), 32'h1);
        tick();
        chk("st_req_state", 32'(a_state), 32'(REQ));
        chk("st_req",       32'(bus_a.req), 32'h1);
        chk("st_addr",      bus_a.addr, 32'h100);
        chk("st_we",        32'(bus_a.we), 32'hF);
        chk("st_wdata",     bus_a.wdata, 32'hCAFEBABE);
        chk("st_req_stall", 32'(a_stall), 32'h1);
        cpu_we = 4'h0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        tick();
        chk("st_done_state", 32'(a_state), 32'(DONE));
        chk("st_done_req",   32'(bus_a.req), 32'h0);
        chk("st_done_stall", 32'(a_stall), 32'h0);
        chk("st_done_err",   32'(a_err), 32'h0);
        s_gnt = 1'b0;
        tick();
        chk("st_back_idle", 32'(a_state), 32'(IDLE));

        // Load with three ungranted REQ cycles, gnt+rvalid together, data later
        cpu_re = 1'b1; cpu_addr = 32'h204;
        tick();
        chk("ld_req1_addr", bus_a.addr, 32'h204);
        chk("ld_req1_req",  32'(bus_a.req), 32'h1);
        cpu_re = 1'b0; cpu_addr = 32'hFFF;
        tick();
        tick();
        chk("ld_req3_state", 32'(a_state), 32'(REQ));
        chk("ld_req3_addr",  bus_a.addr, 32'h204);
        chk("ld_req3_stall", 32'(a_stall), 32'h1);
        tick();
        s_gnt = 1'b1; s_rvalid = 1'b1; s_rdata = 32'hDEADBEEF;
        tick();
        chk("ld_wait_state", 32'(a_state), 32'(WAIT_R));
        chk("ld_wait_req",   32'(bus_a.req), 32'h0);
        chk("ld_wait_stall", 32'(a_stall), 32'h1);
        chk("ld_same_cycle_rvalid", a_rdata, 32'h0);
        s_gnt = 1'b0; s_rvalid = 1'b0;
        tick();
        s_rvalid = 1'b1; s_rdata = 32'h12345678;
        tick();
        chk("ld_done_state", 32'(a_state), 32'(DONE));
        chk("ld_done_rdata", a_rdata, 32'h12345678);
        chk("ld_done_stall", 32'(a_stall), 32'h0);
        chk("ld_done_err",   32'(a_err), 32'h0);
        s_rvalid = 1'b0; s_rdata = 32'h0;
        tick();
        chk("ld_hold_rdata", a_rdata, 32'h12345678);
        s_rvalid = 1'b1; s_rdata = 32'h00000BAD;
        tick();
        chk("idle_rvalid_state", 32'(a_state), 32'(IDLE));
        chk("idle_rvalid_rdata", a_rdata, 32'h12345678);
        s_rvalid = 1'b0; s_rdata = 32'h0;

        // Back-to-back: store, then a load held on the core inputs
        cpu_we = 4'h3; cpu_addr = 32'h300; cpu_wdata = 32'h11112222; s_gnt = 1'b1;
        tick();
        chk("b2b_st_state", 32'(a_state), 32'(REQ));
        chk("b2b_st_we",    32'(bus_a.we), 32'h3);
        cpu_we = 4'h0; cpu_re = 1'b1; cpu_addr = 32'h404;
        tick();
        chk("b2b_done_state", 32'(a_state), 32'(DONE));
        chk("b2b_done_stall", 32'(a_stall), 32'h0);
        tick();
        chk("b2b_idle_state", 32'(a_state), 32'(IDLE));
        chk("b2b_idle_stall", 32'(a_stall), 32'h1);
        tick();
        chk("b2b_ld_state", 32'(a_state), 32'(REQ));
        chk("b2b_ld_addr",  bus_a.addr, 32'h404);
        chk("b2b_ld_we",    32'(bus_a.we), 32'h0);
        tick();
        chk("b2b_wait_state", 32'(a_state), 32'(WAIT_R));
        s_gnt = 1'b0; cpu_re = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h55AA55AA;
        tick();
        chk("b2b_ld_done", 32'(a_state), 32'(DONE));
        chk("b2b_ld_rdata", a_rdata, 32'h55AA55AA);
        s_rvalid = 1'b0; s_rdata = 32'h0;
        tick();
        tick();
        chk("b2b_no_dup_state", 32'(a_state), 32'(IDLE));
        chk("b2b_no_dup_req",   32'(bus_a.req), 32'h0);

        // Byte store to a misaligned address
        cpu_we = 4'b0100; cpu_addr = 32'h103; cpu_wdata = 32'h00AB0000;
        tick();
        chk("byte_addr",  bus_a.addr, 32'h100);
        chk("byte_we",    32'(bus_a.we), 32'h4);
        chk("byte_wdata", bus_a.wdata, 32'h00AB0000);
        s_gnt = 1'b1; cpu_we = 4'h0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        tick();
        chk("byte_done", 32'(a_state), 32'(DONE));
        s_gnt = 1'b0;
        tick();

        // Reset in WAIT_R, then a stale rvalid after reset is released
        cpu_re = 1'b1; cpu_addr = 32'h500;
        tick();
        s_gnt = 1'b1; cpu_re = 1'b0;
        tick();
        chk("rmid_wait_state", 32'(a_state), 32'(WAIT_R));
        s_gnt = 1'b0; rst = 1'b1;
        tick();
        chk("rmid_state", 32'(a_state), 32'(IDLE));
        chk("rmid_addr",  bus_a.addr, 32'h0);
        chk("rmid_rdata", a_rdata, 32'h0);
        chk("rmid_req",   32'(bus_a.req), 32'h0);
        chk("rmid_stall", 32'(a_stall), 32'h0);
        rst = 1'b0;
        tick();
        s_rvalid = 1'b1; s_rdata = 32'h00000099;
        tick();
        chk("rmid_late_state", 32'(a_state), 32'(IDLE));
        chk("rmid_late_rdata", a_rdata, 32'h0);
        s_rvalid = 1'b0; s_rdata = 32'h0;

        // Watchdog on u_to: first a good load so rdata is nonzero
        cpu_re = 1'b1; cpu_addr = 32'h600;
        tick();
        s_gnt = 1'b1; cpu_re = 1'b0;
        tick();
        s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'hA5A5A5A5;
        tick();
        chk("to_pre_rdata", b_rdata, 32'hA5A5A5A5);
        chk("to_pre_err",   32'(b_err), 32'h0);
        s_rvalid = 1'b0; s_rdata = 32'h0;
        tick();

        // Load that is never granted: DONE after 4 REQ cycles
        cpu_re = 1'b1; cpu_addr = 32'h700;
        tick();
        cpu_re = 1'b0;
        chk("to_req1_state", 32'(b_state), 32'(REQ));
        chk("to_req1_req",   32'(bus_b.req), 32'h1);
        tick();
        tick();
        tick();
        chk("to_req4_state", 32'(b_state), 32'(REQ));
        chk("to_req4_err",   32'(b_err), 32'h0);
        chk("to_req4_stall", 32'(b_stall), 32'h1);
        tick();
        chk("to_done_state", 32'(b_state), 32'(DONE));
        chk("to_done_err",   32'(b_err), 32'h1);
        chk("to_done_rdata", b_rdata, 32'h0);
        chk("to_done_req",   32'(bus_b.req), 32'h0);
        chk("to_done_stall", 32'(b_stall), 32'h0);
        tick();
        chk("to_idle_state", 32'(b_state), 32'(IDLE));
        chk("to_idle_err",   32'(b_err), 32'h0);
        chk("to_idle_req",   32'(bus_b.req), 32'h0);
        s_rvalid = 1'b1; s_rdata = 32'h00000077;
        tick();
        chk("to_late_rdata", b_rdata, 32'h0);
        chk("to_late_state", 32'(b_state), 32'(IDLE));
        s_rvalid = 1'b0; s_rdata = 32'h0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_bus_ctrl.md
Name: dmem_bus_ctrl

Overview:
- Sits directly downstream of the CPU core's data-memory port (the MEM stage's address/wdata/byte-WE outputs and rdata input).
- Converts the core's single-cycle-assumed access into a request/grant/rvalid bus transaction to a variable-latency data memory.
- Holds the core with a stall while the transaction is outstanding.
- Provides a watchdog timeout so a dead slave cannot hang the core.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles spent in REQ+WAIT_R before abort; legal range 1..65535.
- CNT_W, 16: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- cpu_re_i  in  1  load request from core
- cpu_we_i  in  4  byte write enables from core; nonzero = store
- cpu_addr_i  in  32  byte address
- cpu_wdata_i  in  32  store data, byte lanes aligned to cpu_we_i
- cpu_rdata_o  out  32  load data, valid in the DONE cycle and held until next DONE
- cpu_stall_o  out  1  core must hold its state while high
- cpu_err_o  out  1  one-cycle pulse in DONE when the transaction timed out
- bus_req_o  out  1  bus request
- bus_addr_o  out  32  word address {addr[31:2],2'b00}
- bus_we_o  out  4  byte write enables, 0 = read
- bus_wdata_o  out  32  write data
- bus_gnt_i  in  1  slave accepted request this cycle
- bus_rvalid_i  in  1  read data valid
- bus_rdata_i  in  32  read data

Behaviour:
- Access request acc = cpu_re_i | (|cpu_we_i). When cpu_we_i is nonzero, the access is a store regardless of cpu_re_i.
- Reset values:
  - state IDLE; all outputs 0.
  - bus_req_o=0, bus_we_o=0, bus_addr_o=0, bus_wdata_o=0.
  - cpu_rdata_o=0, cpu_err_o=0, timeout counter 0.
- States and transitions:
  - IDLE → REQ when acc. On that edge, latch addr, wdata and we into the bus output registers.
  - REQ: bus_req_o=1; bus outputs held stable until grant.
    - On bus_gnt_i: store → DONE; load → WAIT_R.
  - WAIT_R: bus_req_o=0. On bus_rvalid_i, capture bus_rdata_i into cpu_rdata_o and go to DONE.
  - DONE: one cycle, then always → IDLE. cpu_rdata_o is valid here.
  - Timeout: the counter clears on IDLE→REQ and increments each cycle in REQ or WAIT_R. When it equals TIMEOUT_CYCLES:
    - go to DONE with cpu_err_o=1;
    - for a load, cpu_rdata_o=0;
    - bus_req_o drops on the following edge.
- cpu_stall_o (combinational) = (state==IDLE & acc) | state==REQ | state==WAIT_R. It is 0 in DONE and in IDLE with no access.
- Latency, in cycles from acc asserted in IDLE to DONE, with grant the first cycle in REQ:
  - store: 2;
  - load with rvalid the cycle after grant: 3.
- Boundary conditions:
  - bus_gnt_i and bus_rvalid_i in the same REQ cycle for a load: grant is taken. rvalid is ignored, because the slave must not return data before the cycle after grant.
  - bus_rvalid_i or bus_gnt_i in IDLE or DONE: ignored, with no state change.
  - Late rvalid after a timeout: ignored.
  - cpu_* changes while in REQ/WAIT_R/DONE: ignored, since the latched copy drives the bus.
  - acc still high in DONE: not accepted that cycle. It is treated as a new access in the following IDLE cycle, because the core has advanced.
  - rst mid-transaction: next edge gives IDLE with all outputs at reset values. An in-flight slave response is ignored.
  - Misaligned address: low 2 bits are dropped on bus_addr_o; the core presents lane-aligned data. No error is raised.
  - The timeout counter saturates and never wraps.

Decomposition:
- Package dmem_pkg holds:
  - the state enum typedef (IDLE, REQ, WAIT_R, DONE), 2 bits;
  - the ACC_STORE/ACC_LOAD helper constant;
  - the default TIMEOUT_CYCLES constant.
- No sub-module is required. The FSM, latch registers and timeout counter live in one module.

Test Plan:
- Store: cpu_we_i=4'hF, addr=0x100, wdata=0xCAFEBABE, gnt the first REQ cycle → bus_req_o high 1 cycle with addr 0x100/we F/wdata CAFEBABE; stall high 2 cycles; DONE on cycle 2; err=0.
- Load with wait states: cpu_re_i=1, addr=0x204; gnt after 3 REQ cycles, rvalid 2 cycles later with 0x12345678 → bus_addr_o=0x204 stable throughout REQ; cpu_rdata_o=0x12345678 in DONE and held afterwards; stall low only in DONE.
- Timeout: TIMEOUT_CYCLES=4, load, gnt never asserted → DONE after 4 cycles in REQ; cpu_err_o pulses 1 cycle; cpu_rdata_o=0; bus_req_o=0 next cycle.
- Back-to-back: store then a load held continuously on cpu_* → sequence IDLE,REQ,DONE,IDLE,REQ,WAIT_R,DONE; no access is dropped or duplicated.
- Reset mid-op: rst asserted in WAIT_R, then rvalid arrives 1 cycle after rst deasserts → all outputs 0, state IDLE, rvalid ignored, cpu_rdata_o stays 0.
- Byte store: we=4'b0100, addr=0x103 → bus_addr_o=0x100, bus_we_o=4'b0100.
